// File: rtl/reg_file_3p_if.sv
// Bus between the datapath and the 3-port register file: two read ports,
// one write port, plus the ready and debug write-count status lines.
interface reg_file_3p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] regaddr1;
  logic [ADDR_W-1:0] regaddr2;
  logic [ADDR_W-1:0] regaddr3;
  logic              RegWr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              ready;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output regaddr1, regaddr2, regaddr3, RegWr, wdata,
    input  rdata1, rdata2, ready, wr_count
  );

  modport slave (
    input  regaddr1, regaddr2, regaddr3, RegWr, wdata,
    output rdata1, rdata2, ready, wr_count
  );
endinterface

// File: rtl/reg_file_3p.sv
// 32x32 MIPS register file: two combinational reads, one synchronous write,
// post-reset clear engine and saturating write counter. Macro: REGFILE_BYPASS_EN.
module reg_file_3p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_3p_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic              ready, ready_nxt;
  logic [CNT_W-1:0]  wr_count, wr_count_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              wr_req;

  assign wr_req = (state == RUN) && bus.RegWr && (bus.regaddr3 != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      ready    <= 1'b0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      clr_idx  <= clr_idx_nxt;
      ready    <= ready_nxt;
      wr_count <= wr_count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_idx_nxt  = clr_idx;
    ready_nxt    = ready;
    wr_count_nxt = wr_count;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (&clr_idx) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        // Counter holds at all-ones instead of wrapping.
        if (wr_req && (wr_count != '1)) begin
          wr_count_nxt = wr_count + CNT_W'(1);
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // The array has no reset of its own; the clear engine owns it until RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_req) begin
        regs[bus.regaddr3] <= bus.wdata;
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if ((state == RUN) && (bus.regaddr1 != '0)) begin
      rdata1 = regs[bus.regaddr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_req && (bus.regaddr1 == bus.regaddr3)) begin
        rdata1 = bus.wdata;
      end
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if ((state == RUN) && (bus.regaddr2 != '0)) begin
      rdata2 = regs[bus.regaddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_req && (bus.regaddr2 == bus.regaddr3)) begin
        rdata2 = bus.wdata;
      end
`endif
    end
  end

  assign bus.rdata1   = rdata1;
  assign bus.rdata2   = rdata2;
  assign bus.ready    = ready;
  assign bus.wr_count = wr_count;
endmodule
